// File: rtl/ex_muldiv_pkg.sv
// Shared defines for the EX-stage multiply/divide unit: field widths, instruction encodings, op codes.
package ex_muldiv_pkg;

    localparam int unsigned INST_IDX_W  = 6;
    localparam int unsigned INST_TYPE_W = 3;
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned OP_W        = 3;

    localparam logic [INST_IDX_W-1:0] idMUL    = 6'd40;
    localparam logic [INST_IDX_W-1:0] idMULH   = 6'd41;
    localparam logic [INST_IDX_W-1:0] idMULHSU = 6'd42;
    localparam logic [INST_IDX_W-1:0] idMULHU  = 6'd43;
    localparam logic [INST_IDX_W-1:0] idDIV    = 6'd44;
    localparam logic [INST_IDX_W-1:0] idDIVU   = 6'd45;
    localparam logic [INST_IDX_W-1:0] idREM    = 6'd46;
    localparam logic [INST_IDX_W-1:0] idREMU   = 6'd47;

    localparam logic [INST_TYPE_W-1:0] typeMULDIV = 3'd5;
    localparam logic [REG_IDX_W-1:0]   regNOP     = 5'd0;
    localparam logic [31:0]            ZERO32     = 32'd0;

    // Divide-class ops occupy the upper half of the encoding
    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    function automatic md_op_e idx_to_op(input logic [INST_IDX_W-1:0] idx);
        md_op_e op;
        case (idx)
            idMULH:   op = OP_MULH;
            idMULHSU: op = OP_MULHSU;
            idMULHU:  op = OP_MULHU;
            idDIV:    op = OP_DIV;
            idDIVU:   op = OP_DIVU;
            idREM:    op = OP_REM;
            idREMU:   op = OP_REMU;
            default:  op = OP_MUL;
        endcase
        return op;
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative radix-2 datapath: shift-add multiply or restoring divide on magnitudes, sign fixed on the last step.
module ex_muldiv_core
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done_c,
    output logic [DATA_W-1:0] o_result_c
);

    localparam int unsigned W2    = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    md_op_e             r_op;
    logic               r_active;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic [W2-1:0]      r_acc;
    logic [DATA_W-1:0]  r_b;

    md_op_e             w_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_neg;
    logic [DATA_W-1:0]  w_a_mag;
    logic [DATA_W-1:0]  w_b_mag;
    logic [DATA_W:0]    w_sum;
    logic [W2:0]        w_shl;
    logic [DATA_W:0]    w_diff;
    logic [W2-1:0]      w_nxt;
    logic [DATA_W-1:0]  w_hi;
    logic [DATA_W-1:0]  w_lo;
    logic [DATA_W-1:0]  w_mul_hi;

    assign w_op = md_op_e'(i_op);

    // Operand magnitudes and final result sign, decided once at start
    always_comb begin
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
        w_neg   = 1'b0;
        if (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM})
            w_a_neg = i_a[DATA_W-1];
        if (w_op inside {OP_MULH, OP_DIV, OP_REM})
            w_b_neg = i_b[DATA_W-1];
        case (w_op)
            OP_MULH, OP_MULHSU: w_neg = w_a_neg ^ w_b_neg;
            OP_DIV:             w_neg = (w_a_neg ^ w_b_neg) && (i_b != '0);
            OP_REM:             w_neg = w_a_neg;
            default:            w_neg = 1'b0;
        endcase
        w_a_mag = w_a_neg ? -i_a : i_a;
        w_b_mag = w_b_neg ? -i_b : i_b;
    end

    // One iteration: accumulator holds {partial hi, multiplier} or {remainder, quotient}
    always_comb begin
        w_sum  = {1'b0, r_acc[W2-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_shl  = {r_acc, 1'b0};
        w_diff = w_shl[W2:DATA_W] - {1'b0, r_b};
        if (is_div_op(r_op)) begin
            if (!w_diff[DATA_W])
                w_nxt = {w_diff[DATA_W-1:0], w_shl[DATA_W-1:1], 1'b1};
            else
                w_nxt = w_shl[W2-1:0];
        end else begin
            w_nxt = {w_sum, r_acc[DATA_W-1:1]};
        end
        w_hi = w_nxt[W2-1:DATA_W];
        w_lo = w_nxt[DATA_W-1:0];
        // Upper half of the 64-bit two's complement negation
        w_mul_hi = r_neg ? (~w_hi + DATA_W'(w_lo == '0)) : w_hi;
    end

    always_comb begin
        o_result_c = '0;
        case (r_op)
            OP_MUL:                       o_result_c = w_lo;
            OP_MULH, OP_MULHSU, OP_MULHU: o_result_c = w_mul_hi;
            OP_DIV, OP_DIVU:              o_result_c = r_neg ? -w_lo : w_lo;
            default:                      o_result_c = r_neg ? -w_hi : w_hi;
        endcase
    end

    assign o_done_c = r_active && (r_cnt == CNT_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_op     <= OP_MUL;
            r_active <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
        end else if (i_flush) begin
            r_active <= 1'b0;
        end else if (i_start) begin
            r_op     <= w_op;
            r_active <= 1'b1;
            r_neg    <= w_neg;
            r_cnt    <= '0;
            r_acc    <= {{DATA_W{1'b0}}, w_a_mag};
            r_b      <= w_b_mag;
        end else if (r_active) begin
            r_acc <= w_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST)
                r_active <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: IDLE/BUSY/DONE control, pipeline stall and registered writeback toward EX_MEM.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    input  logic [INST_IDX_W-1:0]  instIdx_in,
    input  logic [INST_TYPE_W-1:0] instType_in,
    input  logic [DATA_W-1:0]      rs1Data_in,
    input  logic [DATA_W-1:0]      rs2Data_in,
    input  logic                   rdE_in,
    input  logic [REG_IDX_W-1:0]   rdIdx_in,
    input  logic                   flush_in,
    output logic                   stall_out,
    output logic                   valid_out,
    output logic                   rdE_out,
    output logic [REG_IDX_W-1:0]   rdIdx_out,
    output logic [DATA_W-1:0]      rdData_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                r_state;
    logic                  r_rd_e;
    logic [REG_IDX_W-1:0]  r_rd_idx;

    logic                  w_accept;
    logic                  w_core_done;
    logic [DATA_W-1:0]     w_core_result;
    logic [OP_W-1:0]       w_op;

    assign w_op     = OP_W'(idx_to_op(instIdx_in));
    assign w_accept = rst_in && (r_state == S_IDLE) && valid_in
                      && (instType_in == typeMULDIV) && !flush_in;

    // Holds ID_EX from the accept cycle until the result is ready
    assign stall_out = w_accept || (rst_in && (r_state == S_BUSY));

    ex_muldiv_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_start    (w_accept),
        .i_flush    (flush_in),
        .i_op       (w_op),
        .i_a        (rs1Data_in),
        .i_b        (rs2Data_in),
        .o_done_c   (w_core_done),
        .o_result_c (w_core_result)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_rd_e     <= 1'b0;
            r_rd_idx   <= regNOP;
            valid_out  <= 1'b0;
            rdE_out    <= 1'b0;
            rdIdx_out  <= regNOP;
            rdData_out <= DATA_W'(ZERO32);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_BUSY;
                        r_rd_e   <= rdE_in;
                        r_rd_idx <= rdIdx_in;
                    end
                end
                S_BUSY: begin
                    // Flush wins over completion in the same cycle
                    if (flush_in) begin
                        r_state <= S_IDLE;
                    end else if (w_core_done) begin
                        r_state    <= S_DONE;
                        valid_out  <= 1'b1;
                        rdE_out    <= r_rd_e && (r_rd_idx != regNOP);
                        rdIdx_out  <= r_rd_idx;
                        rdData_out <= w_core_result;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    valid_out  <= 1'b0;
                    rdE_out    <= 1'b0;
                    rdIdx_out  <= regNOP;
                    rdData_out <= DATA_W'(ZERO32);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: result table, latency/stall timing, flush and async reset sequences.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam logic [INST_TYPE_W-1:0] TYPE_ALU = 3'd1;
    localparam int NVEC = 19;

    logic        clk_in;
    logic        rst_in;
    logic        valid_in;
    logic [5:0]  instIdx_in;
    logic [2:0]  instType_in;
    logic [31:0] rs1Data_in;
    logic [31:0] rs2Data_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic        flush_in;
    logic        stall_out;
    logic        valid_out;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [NVEC];

    ex_muldiv #(.DATA_W(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .instIdx_in  (instIdx_in),
        .instType_in (instType_in),
        .rs1Data_in  (rs1Data_in),
        .rs2Data_in  (rs2Data_in),
        .rdE_in      (rdE_in),
        .rdIdx_in    (rdIdx_in),
        .flush_in    (flush_in),
        .stall_out   (stall_out),
        .valid_out   (valid_out),
        .rdE_out     (rdE_out),
        .rdIdx_out   (rdIdx_out),
        .rdData_out  (rdData_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outs_zero(input string name);
        chk({name, "_stall"}, {31'b0, stall_out}, 32'd0);
        chk({name, "_valid"}, {31'b0, valid_out}, 32'd0);
        chk({name, "_rde"},   {31'b0, rdE_out},   32'd0);
        chk({name, "_rdidx"}, {27'b0, rdIdx_out}, 32'd0);
        chk({name, "_data"},  rdData_out,         32'd0);
    endtask

    task automatic apply_op(input logic [5:0] idx, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        valid_in    = 1'b1;
        instType_in = typeMULDIV;
        instIdx_in  = idx;
        rs1Data_in  = a;
        rs2Data_in  = b;
        rdE_in      = 1'b1;
        rdIdx_in    = rd;
    endtask

    task automatic clear_inputs();
        valid_in    = 1'b0;
        instType_in = TYPE_ALU;
        instIdx_in  = 6'd0;
        rs1Data_in  = 32'hDEAD_BEEF;
        rs2Data_in  = 32'h1234_5678;
        rdE_in      = 1'b0;
        rdIdx_in    = 5'd17;
    endtask

    // Called at a falling edge; returns at a falling edge in IDLE
    task automatic run_op(input string name, input logic [5:0] idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int  stalls;
        int  lat;
        bit  seen;
        apply_op(idx, a, b, rd);
        #1;
        chk({name, "_stall_acc"}, {31'b0, stall_out}, 32'd1);
        @(posedge clk_in);
        #1;
        clear_inputs();
        stalls = 1;
        seen   = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk_in);
            if (valid_out) begin
                seen = 1'b1;
                lat  = k;
                chk({name, "_stall_done"}, {31'b0, stall_out}, 32'd0);
                chk({name, "_data"},  rdData_out,         exp);
                chk({name, "_rde"},   {31'b0, rdE_out},   {31'b0, (rd != 5'd0)});
                chk({name, "_rdidx"}, {27'b0, rdIdx_out}, {27'b0, rd});
            end else if (stall_out) begin
                stalls++;
            end
        end
        chk({name, "_seen"},    {31'b0, seen}, 32'd1);
        chk({name, "_latency"}, 32'(lat),      32'd33);
        chk({name, "_stalls"},  32'(stalls),   32'd33);
        @(negedge clk_in);
        chk({name, "_valid_drop"}, {31'b0, valid_out}, 32'd0);
        chk({name, "_data_drop"},  rdData_out,         32'd0);
    endtask

    initial begin
        int vcount;

        tbl[0]  = '{idMUL,    32'd7,          32'd6,          5'd5,  32'd42};
        tbl[1]  = '{idMULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000};
        tbl[2]  = '{idMULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE};
        tbl[3]  = '{idMULHSU, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF};
        tbl[4]  = '{idDIV,    32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD};
        tbl[5]  = '{idREM,    32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF};
        tbl[6]  = '{idDIVU,   32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF};
        tbl[7]  = '{idREMU,   32'd5,          32'd0,          5'd8,  32'd5};
        tbl[8]  = '{idDIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000};
        tbl[9]  = '{idREM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0};
        tbl[10] = '{idMUL,    32'd3,          32'd4,          5'd0,  32'd12};
        tbl[11] = '{idDIV,    32'hFFFF_FFF9,  32'd0,          5'd11, 32'hFFFF_FFFF};
        tbl[12] = '{idREM,    32'hFFFF_FFF9,  32'd0,          5'd12, 32'hFFFF_FFF9};
        tbl[13] = '{idMUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd13, 32'd1};
        tbl[14] = '{idMULH,   32'hFFFF_FFFD,  32'd5,          5'd14, 32'hFFFF_FFFF};
        tbl[15] = '{idMULHU,  32'h8000_0000,  32'd4,          5'd31, 32'd2};
        tbl[16] = '{idREMU,   32'd100,        32'd7,          5'd15, 32'd2};
        tbl[17] = '{idDIV,    32'd7,          32'hFFFF_FFFE,  5'd16, 32'hFFFF_FFFD};
        tbl[18] = '{idREM,    32'd7,          32'hFFFF_FFFE,  5'd18, 32'd1};

        // Reset held with a live MULDIV request on the inputs: nothing may stall or emit
        rst_in   = 1'b0;
        flush_in = 1'b0;
        apply_op(idMUL, 32'd9, 32'd9, 5'd3);
        #12;
        chk_outs_zero("reset");
        @(negedge clk_in);
        clear_inputs();
        rst_in = 1'b1;
        @(negedge clk_in);

        foreach (tbl[i])
            run_op($sformatf("v%0d", i), tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);

        // Non-MULDIV instruction is ignored
        valid_in    = 1'b1;
        instType_in = TYPE_ALU;
        instIdx_in  = idMUL;
        #1;
        chk("alu_stall", {31'b0, stall_out}, 32'd0);
        @(negedge clk_in);
        clear_inputs();
        vcount = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk_in);
            if (valid_out || stall_out) vcount++;
        end
        chk("alu_no_activity", 32'(vcount), 32'd0);

        // Flush in the accept cycle blocks the accept
        apply_op(idMUL, 32'd2, 32'd3, 5'd4);
        flush_in = 1'b1;
        #1;
        chk("flush_acc_stall", {31'b0, stall_out}, 32'd0);
        @(negedge clk_in);
        clear_inputs();
        flush_in = 1'b0;
        #1;
        chk("flush_acc_idle", {31'b0, stall_out}, 32'd0);

        // Flush at BUSY cycle 10
        @(negedge clk_in);
        apply_op(idDIVU, 32'd1000, 32'd3, 5'd5);
        @(posedge clk_in);
        #1;
        clear_inputs();
        repeat (10) @(negedge clk_in);
        chk("flush10_busy_stall", {31'b0, stall_out}, 32'd1);
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        @(negedge clk_in);
        chk("flush10_stall", {31'b0, stall_out}, 32'd0);
        chk("flush10_valid", {31'b0, valid_out}, 32'd0);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (valid_out) vcount++;
        end
        chk("flush10_no_result", 32'(vcount), 32'd0);

        // Flush in the last BUSY cycle beats completion
        apply_op(idMUL, 32'd5, 32'd5, 5'd6);
        @(posedge clk_in);
        #1;
        clear_inputs();
        repeat (32) @(negedge clk_in);
        chk("flush32_busy_stall", {31'b0, stall_out}, 32'd1);
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        @(negedge clk_in);
        chk("flush32_valid", {31'b0, valid_out}, 32'd0);
        chk("flush32_stall", {31'b0, stall_out}, 32'd0);
        @(negedge clk_in);
        chk("flush32_valid_next", {31'b0, valid_out}, 32'd0);

        // Asynchronous reset at BUSY cycle 20
        apply_op(idMUL, 32'd11, 32'd13, 5'd7);
        @(posedge clk_in);
        #1;
        clear_inputs();
        repeat (20) @(negedge clk_in);
        chk("rst20_busy_stall", {31'b0, stall_out}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk_outs_zero("rst20");
        @(negedge clk_in);
        rst_in = 1'b1;
        run_op("post_rst", idDIVU, 32'd100, 32'd7, 5'd9, 32'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
